// File: rtl/intpipe_pkg.sv
// rtl/intpipe_pkg.sv - shared widths and state encoding for the integer register file
package intpipe_pkg;
  localparam int REG_W = 16;
  localparam int NREG  = 8;
  localparam int SEL_W = 3;
  localparam int FLG_W = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;
endpackage

// File: rtl/int_regfile_fwd.sv
// rtl/int_regfile_fwd.sv - read-port forwarding mux
// Priority: same-cycle writeback, then pending buffer, then committed array.
module int_regfile_fwd
  import intpipe_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [REG_W-1:0] wr_data,
  input  logic             pend_valid,
  input  logic [SEL_W-1:0] pend_sel,
  input  logic [REG_W-1:0] pend_data,
  input  logic [REG_W-1:0] arr_data,
  output logic [REG_W-1:0] data
);
  always_comb begin
    data = arr_data;
    if (wr_en && (wr_sel == sel)) begin
      data = wr_data;
    end else if (pend_valid && (pend_sel == sel)) begin
      data = pend_data;
    end
  end
endmodule

// File: rtl/int_regfile.sv
// rtl/int_regfile.sv - integer register file with pending writeback and flag register
// After reset the array is cleared one entry per cycle before the pipeline is released.
module int_regfile
  import intpipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] as,
  input  logic [SEL_W-1:0] bs,
  output logic [REG_W-1:0] adat,
  output logic [REG_W-1:0] bdat,
  input  logic [SEL_W-1:0] cs,
  input  logic [REG_W-1:0] cin,
  input  logic             cwri,
  input  logic [FLG_W-1:0] flgin,
  input  logic             flgwri,
  output logic [FLG_W-1:0] flgout,
  output logic             regwt,
  input  logic [SEL_W-1:0] dbgsel,
  output logic [REG_W-1:0] dbgdat
);
  rf_state_e        state;
  rf_state_e        state_nxt;
  logic [SEL_W-1:0] clr_cnt;
  logic [REG_W-1:0] regs [NREG];
  logic             pend_valid;
  logic [SEL_W-1:0] pend_sel;
  logic [REG_W-1:0] pend_data;
  logic             run;
  logic             wr_en;
  logic [REG_W-1:0] fwd_a;
  logic [REG_W-1:0] fwd_b;

  assign run    = (state == RUN);
  assign wr_en  = run && cwri;
  assign dbgdat = regs[dbgsel];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    regwt     = 1'b1;
    case (state)
      INIT: begin
        if (clr_cnt == SEL_W'(NREG - 1)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        regwt = 1'b0;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_cnt <= '0;
    end else if (!run) begin
      clr_cnt <= clr_cnt + SEL_W'(1);
    end
  end

  // No reset on the array: contents are only guaranteed once INIT has swept it.
  always_ff @(posedge clk) begin
    if (!run) begin
      regs[clr_cnt] <= '0;
    end else if (pend_valid) begin
      regs[pend_sel] <= pend_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid <= 1'b0;
      pend_sel   <= '0;
      pend_data  <= '0;
    end else begin
      pend_valid <= wr_en;
      if (wr_en) begin
        pend_sel  <= cs;
        pend_data <= cin;
      end
    end
  end

  int_regfile_fwd u_fwd_a (
    .sel        (as),
    .wr_en      (wr_en),
    .wr_sel     (cs),
    .wr_data    (cin),
    .pend_valid (pend_valid),
    .pend_sel   (pend_sel),
    .pend_data  (pend_data),
    .arr_data   (regs[as]),
    .data       (fwd_a)
  );

  int_regfile_fwd u_fwd_b (
    .sel        (bs),
    .wr_en      (wr_en),
    .wr_sel     (cs),
    .wr_data    (cin),
    .pend_valid (pend_valid),
    .pend_sel   (pend_sel),
    .pend_data  (pend_data),
    .arr_data   (regs[bs]),
    .data       (fwd_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adat <= '0;
      bdat <= '0;
    end else if (!run) begin
      adat <= '0;
      bdat <= '0;
    end else begin
      adat <= fwd_a;
      bdat <= fwd_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flgout <= '0;
    end else if (run && flgwri) begin
      flgout <= flgin;
    end
  end
endmodule

// File: tb/tb_int_regfile.sv
// tb/tb_int_regfile.sv - self-checking bench for int_regfile
module tb_int_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  as, bs, cs, dbgsel;
  logic [15:0] adat, bdat, cin, dbgdat;
  logic        cwri, flgwri, regwt;
  logic [7:0]  flgin, flgout;

  int errors = 0;
  int checks = 0;

  logic [15:0] model [8];
  logic [15:0] exp_a_q [$];
  logic [15:0] exp_b_q [$];

  always #5 clk = ~clk;

  int_regfile dut (
    .clk    (clk),
    .rst    (rst),
    .as     (as),
    .bs     (bs),
    .adat   (adat),
    .bdat   (bdat),
    .cs     (cs),
    .cin    (cin),
    .cwri   (cwri),
    .flgin  (flgin),
    .flgwri (flgwri),
    .flgout (flgout),
    .regwt  (regwt),
    .dbgsel (dbgsel),
    .dbgdat (dbgdat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    as = 0; bs = 0; cs = 0; cin = 0; cwri = 0;
    flgin = 0; flgwri = 0; dbgsel = 0;
  endtask

  // Count INIT cycles after releasing reset; optionally try a write at INIT cycle 3.
  task automatic release_and_count(input bit inject);
    int n;
    n = 0;
    rst = 1'b1;
    while (regwt === 1'b1 && n < 40) begin
      if (inject && n == 3) begin
        cwri = 1; cs = 3'd1; cin = 16'hFFFF; flgwri = 1; flgin = 8'hFF;
      end else begin
        cwri = 0; flgwri = 0;
      end
      tick();
      n++;
    end
    cwri = 0; flgwri = 0;
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL init_length got=%0d cycles exp=8", n);
    end
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
  endtask

  task automatic cycle(input bit wr, input logic [2:0] wsel, input logic [15:0] wdata,
                       input logic [2:0] ra, input logic [2:0] rb);
    logic [15:0] ea, eb;
    cwri = wr; cs = wsel; cin = wdata; as = ra; bs = rb;
    if (wr) model[wsel] = wdata;
    exp_a_q.push_back(model[ra]);
    exp_b_q.push_back(model[rb]);
    tick();
    cwri = 0;
    ea = exp_a_q.pop_front();
    eb = exp_b_q.pop_front();
    checks++;
    if (adat !== ea) begin
      errors++;
      $display("FAIL read_a sel=%0d got=%h exp=%h", ra, adat, ea);
    end
    checks++;
    if (bdat !== eb) begin
      errors++;
      $display("FAIL read_b sel=%0d got=%h exp=%h", rb, bdat, eb);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (regwt !== 1'b1 || adat !== 16'h0 || bdat !== 16'h0 || flgout !== 8'h0) begin
      errors++;
      $display("FAIL %s regwt=%b adat=%h bdat=%h flgout=%h exp 1/0000/0000/00",
               tag, regwt, adat, bdat, flgout);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    tick(); tick();
    check_reset_outputs("reset_state");
    release_and_count(1'b0);
    for (int i = 0; i < 8; i += 2) cycle(1'b0, 3'd0, 16'h0, 3'(i), 3'(i + 1));
  endtask

  task automatic test_init_ignore();
    rst = 1'b0;
    tick();
    release_and_count(1'b1);
    cycle(1'b0, 3'd0, 16'h0, 3'd1, 3'd1);
    checks++;
    if (flgout !== 8'h00) begin
      errors++;
      $display("FAIL init_flag_ignored got=%h exp=00", flgout);
    end
  endtask

  task automatic test_forward();
    cycle(1'b1, 3'd2, 16'h0005, 3'd2, 3'd0);
    cycle(1'b1, 3'd3, 16'h1111, 3'd0, 3'd2);
    cycle(1'b1, 3'd3, 16'h2222, 3'd1, 3'd3);
    dbgsel = 3'd3;
    #1;
    checks++;
    if (dbgdat !== 16'h1111) begin
      errors++;
      $display("FAIL dbg_committed_only got=%h exp=1111", dbgdat);
    end
    cycle(1'b0, 3'd0, 16'h0, 3'd3, 3'd3);
    checks++;
    if (dbgdat !== 16'h2222) begin
      errors++;
      $display("FAIL dbg_after_commit got=%h exp=2222", dbgdat);
    end
    cycle(1'b1, 3'd4, 16'h0007, 3'd4, 3'd4);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++) begin
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      dbgsel = 3'(i);
      #1;
      checks++;
      if (dbgdat !== model[i]) begin
        errors++;
        $display("FAIL dbg_sweep r%0d got=%h exp=%h", i, dbgdat, model[i]);
      end
    end
  endtask

  task automatic test_flags_and_mid_reset();
    flgwri = 1; flgin = 8'hA5;
    tick();
    flgwri = 0; flgin = 8'h3C;
    checks++;
    if (flgout !== 8'hA5) begin
      errors++;
      $display("FAIL flag_write got=%h exp=a5", flgout);
    end
    tick();
    checks++;
    if (flgout !== 8'hA5) begin
      errors++;
      $display("FAIL flag_hold got=%h exp=a5", flgout);
    end
    cycle(1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd5);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_run_reset");
    tick();
    release_and_count(1'b0);
    cycle(1'b0, 3'd0, 16'h0, 3'd5, 3'd0);
  endtask

  initial begin
    test_reset();
    test_init_ignore();
    test_forward();
    test_back_to_back();
    test_flags_and_mid_reset();
    checks++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", exp_a_q.size(), exp_b_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/int_regfile.md
INT_REGFILE -- requirements
Module: int_regfile

Interface
REQ-001 Parameter: REG_W, 16, register data width.
REQ-002 Parameter: NREG, 8, number of general registers; select width SEL_W = 3.
REQ-003 Parameter: FLG_W, 8, flag register width.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-low.
REQ-006 Port as, input, 3: read-port A register select from the integer pipeline.
REQ-007 Port bs, input, 3: read-port B register select.
REQ-008 Port adat, output, 16: read-port A data, registered.
REQ-009 Port bdat, output, 16: read-port B data, registered.
REQ-010 Port cs, input, 3: writeback register select.
REQ-011 Port cin, input, 16: writeback data.
REQ-012 Port cwri, input, 1: writeback enable.
REQ-013 Port flgin, input, 8: flag value from the pipeline.
REQ-014 Port flgwri, input, 1: flag write enable.
REQ-015 Port flgout, output, 8: current flag register, fed to the pipeline flag input.
REQ-016 Port regwt, output, 1: register-file wait; pipeline stalls while high.
REQ-017 Port dbgsel, input, 3 / dbgdat, output, 16: combinational debug read of the committed array only.

Function
REQ-018 FSM states: INIT (array clear), RUN.
REQ-019 INIT: 3-bit clear counter writes 0 to reg[counter] each cycle, 0..7; on counter==7, go to RUN next edge.
REQ-020 regwt SHALL be 1 in INIT and 0 in RUN; INIT lasts exactly 8 cycles after reset release.
REQ-021 In INIT, cwri and flgwri are ignored; adat/bdat are loaded with 0.
REQ-022 Writeback: in RUN, cwri=1 captures (cs, cin) into a one-deep pending buffer; the buffer commits to the array on the next edge.
REQ-023 Pending buffer is overwritten every cycle cwri=1; commit and new capture in the same edge are both performed.
REQ-024 Read latency: adat/bdat load at the edge following select presentation (1 cycle).
REQ-025 Read forwarding priority: same-cycle write (cwri && cs==sel) > pending buffer (valid && pend_sel==sel) > array.
REQ-026 Ports A and B are independent; as==bs==cs is legal; both ports return the forwarded value.
REQ-027 Flags: flgwri=1 in RUN loads flgin; flgout shows the new value the cycle after; no flag forwarding.
REQ-028 All arithmetic unsigned; no wrap conditions other than the 3-bit clear counter.

Reset
REQ-029 Asserting rst at any time SHALL force: state=INIT, counter=0, pending valid=0, adat=0, bdat=0, flgout=0, regwt=1.
REQ-030 Reset mid-RUN discards any pending write; the array is re-cleared by INIT.
REQ-031 The array itself is not reset asynchronously; it is cleared only by INIT.

Structure
REQ-032 Shared package intpipe_pkg SHALL hold REG_W, NREG, SEL_W, FLG_W and the INIT/RUN state enum.
REQ-033 One sub-module, int_regfile_fwd (combinational forwarding mux per REQ-025), instantiated once per read port.

Verification
REQ-034 Release rst -> regwt=1 for exactly 8 cycles, then 0; reading r0..r7 returns 0x0000.
REQ-035 RUN, cwri=1 cs=2 cin=0x0005 with as=2 same cycle -> adat=0x0005 next cycle.
REQ-036 Writes r3=0x1111 then r3=0x2222 on consecutive cycles, as=3 the following cycle -> adat=0x2222; dbgsel=3 shows 0x2222 after commit.
REQ-037 During INIT cycle 3, cwri=1 cs=1 cin=0xFFFF -> after RUN, reading r1 returns 0x0000.
REQ-038 as=bs=cs=4, cwri=1, cin=0x0007 -> adat=bdat=0x0007 next cycle.
REQ-039 flgwri=1 flgin=0xA5 -> flgout=0xA5 next cycle; then assert rst mid-RUN -> flgout=0x00, adat=bdat=0, regwt=1 immediately.
